// File: rtl/control_unit.sv
// Step sequencer for the simple CPU: decodes ir (III XXX YYY) into bus-mux selects and load enables.
// One micro-step per clock (mv/mvi/nop 2 cycles, add/sub 4); run is the only handshake, honoured in T0.
module control_unit #(
    parameter int OPW = 3,
    parameter int RW  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic [OPW+2*RW-1:0]   ir,
    output logic                  ir_in,
    output logic                  din_en,
    output logic                  gout,
    output logic [RW-1:0]         rout,
    output logic [(2**RW)-1:0]    rin,
    output logic                  a_in,
    output logic                  g_in,
    output logic                  addsub,
    output logic                  done
);
    localparam int NREG = 2**RW;

    typedef enum logic [1:0] {T0, T1, T2, T3} step_t;

    step_t           step;
    step_t           step_nxt;
    logic [OPW-1:0]  op;
    logic [RW-1:0]   x;
    logic [RW-1:0]   y;
    logic            is_arith;

    assign op       = ir[OPW+2*RW-1:2*RW];
    assign x        = ir[2*RW-1:RW];
    assign y        = ir[RW-1:0];
    assign is_arith = (op == OPW'(2)) || (op == OPW'(3));

    always_ff @(posedge clk) begin
        if (rst) begin
            step <= T0;
        end else begin
            step <= step_nxt;
        end
    end

    always_comb begin
        step_nxt = T0;
        ir_in    = 1'b0;
        din_en   = 1'b0;
        gout     = 1'b0;
        rout     = '0;
        rin      = '0;
        a_in     = 1'b0;
        g_in     = 1'b0;
        addsub   = 1'b0;
        done     = 1'b0;
        case (step)
            T0: begin
                ir_in    = run;
                step_nxt = run ? T1 : T0;
            end
            T1: begin
                if (op == OPW'(0)) begin
                    rout = y;
                    rin  = NREG'(1) << x;
                    done = 1'b1;
                end else if (op == OPW'(1)) begin
                    din_en = 1'b1;
                    rin    = NREG'(1) << x;
                    done   = 1'b1;
                end else if (is_arith) begin
                    rout     = x;
                    a_in     = 1'b1;
                    step_nxt = T2;
                end else begin
                    done = 1'b1;
                end
            end
            T2: begin
                // A non-arithmetic opcode here means ir moved under us; fall back to T0 quietly.
                if (is_arith) begin
                    rout     = y;
                    g_in     = 1'b1;
                    addsub   = op[0];
                    step_nxt = T3;
                end
            end
            T3: begin
                if (is_arith) begin
                    gout = 1'b1;
                    rin  = NREG'(1) << x;
                    done = 1'b1;
                end
            end
            default: step_nxt = T0;
        endcase

        // Reset wins over everything, including the T0 ir_in echo of run.
        if (rst) begin
            ir_in  = 1'b0;
            din_en = 1'b0;
            gout   = 1'b0;
            rout   = '0;
            rin    = '0;
            a_in   = 1'b0;
            g_in   = 1'b0;
            addsub = 1'b0;
            done   = 1'b0;
        end
    end
endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench: an instruction-level model predicts every cycle's control word.
module tb_control_unit;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic [8:0] ir  = '0;
    logic       ir_in, din_en, gout, a_in, g_in, addsub, done;
    logic [2:0] rout;
    logic [7:0] rin;

    typedef struct packed {
        logic       ir_in;
        logic       din_en;
        logic       gout;
        logic [2:0] rout;
        logic [7:0] rin;
        logic       a_in;
        logic       g_in;
        logic       addsub;
        logic       done;
    } vec_t;

    vec_t pend[$];
    vec_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    control_unit #(.OPW(3), .RW(3)) dut (
        .clk(clk), .rst(rst), .run(run), .ir(ir),
        .ir_in(ir_in), .din_en(din_en), .gout(gout), .rout(rout), .rin(rin),
        .a_in(a_in), .g_in(g_in), .addsub(addsub), .done(done)
    );

    always #5 clk = ~clk;

    // Instruction -> list of per-cycle control words after the T0 fetch cycle.
    task automatic push_steps(input logic [8:0] i);
        vec_t v;
        logic [2:0] opc = i[8:6];
        logic [2:0] rx  = i[5:3];
        logic [2:0] ry  = i[2:0];
        if (opc == 3'd0) begin
            v = '0; v.rout = ry; v.rin[rx] = 1'b1; v.done = 1'b1; pend.push_back(v);
        end else if (opc == 3'd1) begin
            v = '0; v.din_en = 1'b1; v.rin[rx] = 1'b1; v.done = 1'b1; pend.push_back(v);
        end else if (opc == 3'd2 || opc == 3'd3) begin
            v = '0; v.rout = rx; v.a_in = 1'b1; pend.push_back(v);
            v = '0; v.rout = ry; v.g_in = 1'b1; v.addsub = (opc == 3'd3); pend.push_back(v);
            v = '0; v.gout = 1'b1; v.rin[rx] = 1'b1; v.done = 1'b1; pend.push_back(v);
        end else begin
            v = '0; v.done = 1'b1; pend.push_back(v);
        end
    endtask

    // Drive one cycle's inputs and queue the predicted control word for it.
    task automatic cycle(input logic r, input logic rn, input logic [8:0] i);
        vec_t e;
        @(posedge clk);
        #1;
        rst = r; run = rn; ir = i;
        e = '0;
        if (r) begin
            pend.delete();
        end else if (pend.size() == 0) begin
            e.ir_in = rn;
            if (rn) push_steps(i);
        end else begin
            e = pend.pop_front();
        end
        sbq.push_back(e);
    endtask

    always @(negedge clk) begin
        vec_t a, e;
        cyc++;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            a = '{ir_in, din_en, gout, rout, rin, a_in, g_in, addsub, done};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL ctrl_word cyc=%0d got=%b exp=%b", cyc, a, e);
            end
            checks++;
            if (din_en && gout) begin
                errors++;
                $display("FAIL bus_conflict cyc=%0d got din_en=1 gout=1 exp not both", cyc);
            end
        end
    end

    initial begin
        logic [8:0] cur;
        logic       r, rn;
        int         wait_cnt;

        // Reset with run high, then the directed instruction list.
        cycle(1'b1, 1'b1, 9'b001_010_000);
        cycle(1'b1, 1'b1, 9'b001_010_000);
        cycle(1'b0, 1'b1, 9'b001_010_000);   // T0 fetch mvi r2
        cycle(1'b0, 1'b0, 9'b001_010_000);   // T1
        cycle(1'b0, 1'b0, 9'b001_010_000);   // idle
        cycle(1'b0, 1'b1, 9'b000_101_011);   // mv r5,r3
        cycle(1'b0, 1'b0, 9'b000_101_011);
        cycle(1'b0, 1'b1, 9'b010_001_110);   // add r1,r6
        repeat (3) cycle(1'b0, 1'b0, 9'b010_001_110);
        cycle(1'b0, 1'b1, 9'b011_001_110);   // sub r1,r6
        repeat (3) cycle(1'b0, 1'b0, 9'b011_001_110);
        repeat (4) cycle(1'b0, 1'b1, 9'b010_011_100);   // add, run held high
        repeat (2) cycle(1'b0, 1'b1, 9'b001_111_000);   // mvi back-to-back
        cycle(1'b0, 1'b0, 9'b001_111_000);
        cycle(1'b0, 1'b1, 9'b011_010_001);   // sub, reset in T2
        cycle(1'b0, 1'b0, 9'b011_010_001);
        cycle(1'b1, 1'b0, 9'b011_010_001);
        cycle(1'b0, 1'b0, 9'b011_010_001);
        cycle(1'b0, 1'b0, 9'b011_010_001);
        cycle(1'b0, 1'b1, 9'b110_000_000);   // reserved opcode
        cycle(1'b0, 1'b0, 9'b110_000_000);
        cycle(1'b0, 1'b1, 9'b011_011_011);   // X=Y sub
        repeat (3) cycle(1'b0, 1'b0, 9'b011_011_011);

        // Random traffic; ir only changes while the model is idle.
        cur = '0;
        for (int n = 0; n < 600; n++) begin
            r  = ($urandom_range(0, 99) < 4);
            rn = ($urandom_range(0, 99) < 60);
            if (pend.size() == 0) cur = 9'($urandom_range(0, 511));
            cycle(r, rn, cur);
        end
        cycle(1'b0, 1'b0, cur);

        wait_cnt = 0;
        while (sbq.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d pending exp=0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
